// File: rtl/tx_seq_pkg.sv
// Shared types and helpers for the tx_sequencer byte-burst scheduler.
package tx_seq_pkg;

    // Burst scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Only the low bits of the speed input select the gap.
    localparam int SPEED_W = 2;

    // Gap multiplier applied to GAP_BASE: 0, 1, 2 or 4.
    function automatic logic [2:0] speed_mult(input logic [SPEED_W-1:0] code);
        logic [2:0] mult;
        unique case (code)
            2'd0:    mult = 3'd0;
            2'd1:    mult = 3'd1;
            2'd2:    mult = 3'd2;
            default: mult = 3'd4;
        endcase
        return mult;
    endfunction

endpackage

// File: rtl/tx_sequencer_gap_timer.sv
// gap_timer: loadable down-counter used to time the idle gap between bytes.
// 'expired' is high while the count sits at zero.
module gap_timer #(
    parameter  int GAP_BASE = 1000,
    localparam int CNT_W    = $clog2(4 * GAP_BASE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/tx_sequencer.sv
// tx_sequencer: captures a burst request on 'start' and feeds the UART
// transmitter one byte per valid/ready handshake, with a programmable idle
// gap between bytes. Reports busy/done and a running count of bytes sent.
//
// Build option: define TX_SEQ_INCR_EN to send byte_val, byte_val+1, ...
// (mod 256) instead of repeating byte_val.
module tx_sequencer
    import tx_seq_pkg::*;
#(
    parameter int GAP_BASE = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_val,
    input  logic [7:0] byte_count,
    input  logic [7:0] speed_code,
    input  logic       abort,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] bytes_sent
);

    localparam int CNT_W = $clog2(4 * GAP_BASE + 1);

    state_e               state_q,      state_d;
    logic [7:0]           count_q,      count_d;
    logic [SPEED_W-1:0]   speed_q,      speed_d;
    // tx_data_q doubles as the captured byte register.
    logic [7:0]           tx_data_q,    tx_data_d;
    logic                 tx_valid_q,   tx_valid_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic [7:0]           bytes_sent_q, bytes_sent_d;

    logic                 handshake;
    logic                 gap_load;
    logic [CNT_W-1:0]     gap_value;
    logic                 gap_expired;
    logic                 speed_hi_unused;

    assign handshake       = tx_valid_q && tx_ready;
    assign speed_hi_unused = ^speed_code[7:SPEED_W];

    // The timer holds G-1 so that tx_valid stays low for exactly G cycles:
    // the GAP state is left on the edge where the count has reached zero.
    assign gap_value = CNT_W'(int'(speed_mult(speed_q)) * GAP_BASE - 1);

    gap_timer #(
        .GAP_BASE (GAP_BASE)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (gap_load),
        .value   (gap_value),
        .expired (gap_expired)
    );

    // Next-state and next-output logic for the burst FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        count_d      = count_q;
        speed_d      = speed_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        bytes_sent_d = bytes_sent_q;
        gap_load     = 1'b0;

        // A completed handshake always counts, even on an abort edge.
        if (handshake) begin
            bytes_sent_d = bytes_sent_q + 8'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d      = byte_count;
                    speed_d      = speed_code[SPEED_W-1:0];
                    tx_data_d    = byte_val;
                    bytes_sent_d = 8'd0;
                    busy_d       = 1'b1;
                    if (byte_count == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_SEND;
                        tx_valid_d = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (handshake) begin
                    if (bytes_sent_q + 8'd1 == count_q) begin
                        state_d    = ST_DONE;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
`ifdef TX_SEQ_INCR_EN
                        tx_data_d = tx_data_q + 8'd1;
`endif
                        if (speed_q == '0) begin
                            tx_valid_d = 1'b1;
                        end else begin
                            state_d    = ST_GAP;
                            tx_valid_d = 1'b0;
                            gap_load   = 1'b1;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_expired) begin
                    state_d    = ST_SEND;
                    tx_valid_d = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Abort overrides whatever the burst was about to do.
        if (abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            gap_load   = 1'b0;
        end
    end

    // State and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 8'd0;
            speed_q      <= '0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bytes_sent_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            speed_q      <= speed_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            bytes_sent_q <= bytes_sent_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign bytes_sent = bytes_sent_q;

endmodule
